mem_bus_arbiter: RTL

- Shares one downstream memory port between NREQ requesters: fetch, data access, and the MMU page-table walker that uses satp.
- Sits between the core's request/response channels and the single external bus.
- Round-robin grant. The grant is held for the whole transaction, from request through data_ok.
- Handles requester withdrawal (e.g. on a flush) without corrupting the bus protocol.

---
 rtl/mem_bus_arbiter_if.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Core-side request/response channels plus the single downstream memory port.
// The arbiter masters the downstream port; requesters and memory sit on the slave side.
interface mem_bus_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 64,
  parameter int DW   = 64
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*3-1:0]      req_size;
  logic [NREQ*(DW/8)-1:0] req_strobe;
  logic [NREQ*DW-1:0]     req_wdata;
  logic [NREQ-1:0]        resp_addr_ok;
  logic [NREQ-1:0]        resp_data_ok;
  logic [DW-1:0]          resp_data;
  logic                   resp_err;

  logic                   mreq_valid;
  logic [AW-1:0]          mreq_addr;
  logic [2:0]             mreq_size;
  logic [DW/8-1:0]        mreq_strobe;
  logic [DW-1:0]          mreq_wdata;
  logic                   mresp_addr_ok;
  logic                   mresp_data_ok;
  logic [DW-1:0]          mresp_data;

  modport master (
    input  req_valid, req_addr, req_size, req_strobe, req_wdata,
    input  mresp_addr_ok, mresp_data_ok, mresp_data,
    output resp_addr_ok, resp_data_ok, resp_data, resp_err,
    output mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_wdata
  );

  modport slave (
    output req_valid, req_addr, req_size, req_strobe, req_wdata,
    output mresp_addr_ok, mresp_data_ok, mresp_data,
    input  resp_addr_ok, resp_data_ok, resp_data, resp_err,
    input  mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between NREQ requesters.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that aborts transactions after TIMEOUT cycles.
module mem_bus_arbiter #(
  parameter int NREQ    = 3,
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255,
  localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.master bus,
  output logic [GW-1:0]     grant_id,
  output logic              busy
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   pick, cand;
  logic            pickValid;
  logic            reqHeld;
  logic            timeoutHit;

  logic [AW-1:0]   addr_q;
  logic [2:0]      size_q;
  logic [SW-1:0]   strobe_q;
  logic [DW-1:0]   wdata_q;
  logic [AW-1:0]   selAddr;
  logic [2:0]      selSize;
  logic [SW-1:0]   selStrobe;
  logic [DW-1:0]   selWdata;

  assign selAddr   = bus.req_addr[grant_q*AW +: AW];
  assign selSize   = bus.req_size[grant_q*3 +: 3];
  assign selStrobe = bus.req_strobe[grant_q*SW +: SW];
  assign selWdata  = bus.req_wdata[grant_q*DW +: DW];
  assign reqHeld   = bus.req_valid[grant_q];

  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);

  // First valid requester strictly after the last grant, wrapping around.
  always_comb begin
    pickValid = 1'b0;
    pick      = rr_q;
    cand      = rr_q;
    for (int k = NREQ; k >= 1; k--) begin
      cand = GW'((int'(rr_q) + k) % NREQ);
      if (bus.req_valid[cand]) begin
        pickValid = 1'b1;
        pick      = cand;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A withdrawal in ADDR already ends the transaction silently, so it wins over the watchdog.
  assign timeoutHit = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT - 1)) &&
                      !((state_q == ADDR) && !reqHeld);
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT > 0);
  assign timeoutHit    = 1'b0;
`endif

  // DATA and DRAIN replay the fields captured in ADDR, so a withdrawing requester cannot disturb the bus.
  always_comb begin
    if (state_q == ADDR) begin
      bus.mreq_addr   = selAddr;
      bus.mreq_size   = selSize;
      bus.mreq_strobe = selStrobe;
      bus.mreq_wdata  = selWdata;
    end else begin
      bus.mreq_addr   = addr_q;
      bus.mreq_size   = size_q;
      bus.mreq_strobe = strobe_q;
      bus.mreq_wdata  = wdata_q;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_d             = rr_q;
    bus.mreq_valid   = 1'b0;
    bus.resp_addr_ok = '0;
    bus.resp_data_ok = '0;
    bus.resp_data    = '0;
    bus.resp_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          grant_d = pick;
          rr_d    = pick;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!reqHeld) begin
          state_d = IDLE;
        end else begin
          bus.mreq_valid = 1'b1;
          if (bus.mresp_addr_ok) begin
            bus.resp_addr_ok[grant_q] = 1'b1;
            if (bus.mresp_data_ok) begin
              bus.resp_data_ok[grant_q] = 1'b1;
              bus.resp_data             = bus.mresp_data;
              state_d                   = IDLE;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        bus.mreq_valid = 1'b1;
        if (bus.mresp_data_ok) begin
          bus.resp_data_ok[grant_q] = 1'b1;
          bus.resp_data             = bus.mresp_data;
          state_d                   = IDLE;
        end else if (!reqHeld) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        bus.mreq_valid = 1'b1;
        if (bus.mresp_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeoutHit) begin
      state_d          = IDLE;
      bus.mreq_valid   = 1'b0;
      bus.resp_addr_ok = '0;
      bus.resp_data_ok = '0;
      bus.resp_data    = '0;
      if (state_q != DRAIN) begin
        bus.resp_data_ok[grant_q] = 1'b1;
        bus.resp_err              = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= GW'(NREQ - 1);
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      if (state_q == ADDR) begin
        addr_q   <= selAddr;
        size_q   <= selSize;
        strobe_q <= selStrobe;
        wdata_q  <= selWdata;
      end
    end
  end

endmodule
